// File: rtl/naive_fntt.sv
// ============================================================================
// Module   : naive_fntt
// Brief    : Direct O(n^2) number-theoretic transform over Z_m. One
//            multiply-accumulate per clock; results written one coefficient
//            per n cycles into a registered output array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module naive_fntt #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] data_in    [N-1:0],
  input  logic [W-1:0] array_size,
  input  logic [W-1:0] bit_length,
  input  logic [W-1:0] omegas     [N-1:0],
  input  logic [W-1:0] mod,
  output logic [W-1:0] data_out   [N-1:0],
  output logic         busy,
  output logic         done
);

  localparam int            IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [W:0]    C_N_EXT = (W+1)'(N);
  localparam logic [IW-1:0] C_NM1   = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;

  // Operands captured at the start edge so input changes cannot disturb a run
  logic [W-1:0]  r_x          [N-1:0];
  logic [W-1:0]  r_w          [N-1:0];
  logic [W-1:0]  r_mod;
  logic [W-1:0]  r_bit_length;
  logic [IW-1:0] r_nm1;

  // Loop counters: r_j walks the input, r_k the output coefficient, and
  // r_idx tracks (j*k) mod n incrementally so no general modulo is needed
  logic [IW-1:0] r_j;
  logic [IW-1:0] r_k;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_acc;

  logic [2*W-1:0] w_prod;
  logic [2*W:0]   w_sum;
  logic [2*W:0]   w_div;
  logic [W-1:0]   w_acc_next;
  logic [IW:0]    w_idx_sum;
  logic [IW-1:0]  w_idx_next;
  logic [IW-1:0]  w_start_nm1;
  logic           w_unused;

  // bit_length is latched but has no function in this transform
  assign w_unused = ^r_bit_length;

  // Single MAC datapath, twiddle index update and effective-length decode
  always_comb begin
    w_prod     = {{W{1'b0}}, r_x[r_j]} * {{W{1'b0}}, r_w[r_idx]};
    w_sum      = {1'b0, w_prod} + {{(W+1){1'b0}}, r_acc};
    // A zero modulus is defined to yield zero; divisor forced to 1 to avoid x/0
    w_div      = (r_mod == '0) ? (2*W+1)'(1) : {{(W+1){1'b0}}, r_mod};
    w_acc_next = (r_mod == '0) ? '0 : W'(w_sum % w_div);

    // idx + k < 2n, so one conditional subtraction of n keeps it in range
    w_idx_sum  = {1'b0, r_idx} + {1'b0, r_k};
    if (w_idx_sum > {1'b0, r_nm1}) begin
      w_idx_next = IW'(w_idx_sum - {1'b0, r_nm1} - (IW+1)'(1));
    end else begin
      w_idx_next = w_idx_sum[IW-1:0];
    end

    // Lengths of 0 or above N fall back to the full array
    if ((array_size == '0) || ({1'b0, array_size} > C_N_EXT)) begin
      w_start_nm1 = C_NM1;
    end else begin
      w_start_nm1 = IW'(array_size - W'(1));
    end
  end

  // Control FSM with registered busy/done and the result array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      r_mod        <= '0;
      r_bit_length <= '0;
      r_nm1        <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      for (int i = 0; i < N; i++) begin
        r_x[i]      <= '0;
        r_w[i]      <= '0;
        data_out[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x          <= data_in;
            r_w          <= omegas;
            r_mod        <= mod;
            r_bit_length <= bit_length;
            r_nm1        <= w_start_nm1;
            r_j          <= '0;
            r_k          <= '0;
            r_idx        <= '0;
            r_acc        <= '0;
            for (int i = 0; i < N; i++) begin
              data_out[i] <= '0;
            end
            busy         <= 1'b1;
            r_state      <= S_CALC;
          end
        end

        S_CALC: begin
          if (r_j == r_nm1) begin
            data_out[r_k] <= w_acc_next;
            r_acc         <= '0;
            r_j           <= '0;
            r_idx         <= '0;
            if (r_k == r_nm1) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_k <= r_k + IW'(1);
            end
          end else begin
            r_acc <= w_acc_next;
            r_j   <= r_j + IW'(1);
            r_idx <= w_idx_next;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_naive_fntt.sv
// ============================================================================
// Module   : tb_naive_fntt
// Brief    : Self-checking bench for naive_fntt. A cycle-level reference model
//            predicts busy/done/data_out from the transform definition; fixed
//            scenarios also pin results to hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_naive_fntt;

  localparam int N = 8;
  localparam int W = 8;

  typedef int vec_t [N];

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in  [N-1:0];
  logic [W-1:0] array_size;
  logic [W-1:0] bit_length;
  logic [W-1:0] omegas   [N-1:0];
  logic [W-1:0] mod_v;
  logic [W-1:0] data_out [N-1:0];
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  naive_fntt #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .array_size (array_size),
    .bit_length (bit_length),
    .omegas     (omegas),
    .mod        (mod_v),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_n();
    if (array_size == 0 || array_size > N) return N;
    return int'(array_size);
  endfunction

  function automatic int ref_coef(input int k, input int n, input int m);
    longint s = 0;
    if (m == 0 || k >= n) return 0;
    for (int j = 0; j < n; j++)
      s += longint'(data_in[j]) * longint'(omegas[(j * k) % n]);
    return int'(s % m);
  endfunction

  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_cnt  = 0;
  int   m_n    = N;
  int   m_X   [N];
  int   m_out [N];

  initial for (int i = 0; i < N; i++) begin m_X[i] = 0; m_out[i] = 0; end

  // Coefficient k becomes visible once its n MACs have been clocked
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      for (int i = 0; i < N; i++) m_out[i] <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if ((m_cnt + 1) % m_n == 0)
        m_out[(m_cnt + 1) / m_n - 1] <= m_X[(m_cnt + 1) / m_n - 1];
      if (m_cnt + 1 == m_n * m_n) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (start) begin
      m_n    <= eff_n();
      for (int k = 0; k < N; k++) begin
        m_X[k]   <= ref_coef(k, eff_n(), int'(mod_v));
        m_out[k] <= 0;
      end
      m_busy <= 1'b1;
      m_cnt  <= 0;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    for (int i = 0; i < N; i++)
      check($sformatf("data_out[%0d]", i), data_out[i], m_out[i]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input vec_t xs, input vec_t om, input int sz, input int m);
    for (int i = 0; i < N; i++) begin
      data_in[i] = W'(xs[i]);
      omegas[i]  = W'(om[i]);
    end
    array_size = W'(sz);
    mod_v      = W'(m);
    bit_length = W'($urandom_range(0, 255));
  endtask

  // Called at posedge+1; leaves at start-edge+1 with start released
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 0;
    int bc  = busy ? 1 : 0;
    bit found = 1'b0;
    while (!found && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bc++;
      if (done) found = 1'b1;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bc, exp_lat);
  endtask

  task automatic check_out(input string tag, input vec_t exp);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_out[%0d]", tag, i), data_out[i], exp[i]);
  endtask

  task automatic run(input string tag, input vec_t xs, input vec_t om, input int sz,
                     input int m, input int lat, input vec_t exp);
    @(posedge clk);
    #1;
    load(xs, om, sz, m);
    pulse_start();
    wait_done(tag, lat);
    repeat (2) @(posedge clk);
    #1;
    check_out(tag, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    vec_t om8, om4, x123, ximp, xone, xbig, xred, z, e031, e_ones;
    int   dcount;
    om8    = '{1, 9, 13, 15, 16, 8, 4, 2};
    om4    = '{1, 4, 16, 13, 99, 200, 7, 3};
    x123   = '{1, 2, 3, 0, 0, 0, 0, 0};
    ximp   = '{1, 0, 0, 0, 0, 0, 0, 0};
    xone   = '{1, 1, 1, 1, 1, 1, 1, 1};
    xbig   = '{200, 13, 7, 99, 1, 2, 3, 4};
    xred   = '{18, 36, 20, 34, 0, 0, 0, 0};
    z      = '{0, 0, 0, 0, 0, 0, 0, 0};
    e031   = '{6, 7, 7, 9, 2, 5, 6, 0};
    e_ones = '{1, 1, 1, 1, 1, 1, 1, 1};

    load(z, z, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check_out("reset", z);
    rst_n = 1'b1;

    run("n8_x123", x123, om8, 8, 17, 64, e031);
    run("n4_x123", x123, om4, 4, 17, 16, '{6, 6, 2, 7, 0, 0, 0, 0});
    run("n8_impulse", ximp, om8, 8, 17, 64, e_ones);
    run("n8_ones", xone, om8, 8, 17, 64, '{8, 0, 0, 0, 0, 0, 0, 0});
    run("n8_reduce", xred, om8, 8, 17, 64, e031);
    run("size0", x123, om8, 0, 17, 64, e031);
    run("size200", x123, om8, 200, 17, 64, e031);
    run("n1", '{5, 9, 9, 9, 9, 9, 9, 9}, '{1, 7, 7, 7, 7, 7, 7, 7}, 1, 17, 1,
        '{5, 0, 0, 0, 0, 0, 0, 0});
    run("mod0", xbig, om8, 8, 0, 64, z);
    run("mod1", xbig, om8, 8, 1, 64, z);

    // Restart attempt mid-run with inputs altered after the start edge
    @(posedge clk);
    #1;
    load(x123, om8, 8, 17);
    pulse_start();
    load('{5, 5, 5, 5, 5, 5, 5, 5}, '{3, 3, 3, 3, 3, 3, 3, 3}, 4, 13);
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcount = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("restart_done_pulses", dcount, 1);
    check_out("restart", e031);

    // Reset in the middle of a run
    @(posedge clk);
    #1;
    load(x123, om8, 8, 17);
    pulse_start();
    dcount = 0;
    repeat (29) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check_out("midrst", z);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    run("after_rst", ximp, om8, 8, 17, 64, e_ones);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
